// File: rtl/control_unit.sv
// control_unit: multi-cycle sequencer for the fetch / decode / execute datapath.
// Fetch runs T0-T2 (T1 stretches until mem_ready), T3 decodes IR[31:27] and
// latches it into op_q, T4-T6 execute ALU or MUL/DIV ops, opcode 27 parks the
// block in HALT until clear.
// Optional build macro: CU_STEP_EN -- every instruction completion waits in
// STEP_WAIT for a step pulse before fetching again.
//
// state     | meaning
// RST       | reset, all outputs low
// T0        | PC to MAR, increment PC into Z
// T1        | memory read, held until mem_ready
// T2        | MDR to IR
// T3        | decode opcode, first operand to Y
// T4        | second operand, ALU result into Z
// T5        | write back low result
// T6        | write back high result (MUL/DIV)
// HALT      | stopped until clear
// STEP_WAIT | wait for step pulse (CU_STEP_EN builds only)
module control_unit (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        mem_ready,
    input  logic        step,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        LOin,
    output logic        HIin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic [4:0]  alu_op,
    output logic        halted
);

    typedef enum logic [3:0] {
        RST  = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        T3   = 4'd4,
        T4   = 4'd5,
        T5   = 4'd6,
        T6   = 4'd7,
        HALT = 4'd8
`ifdef CU_STEP_EN
        , STEP_WAIT = 4'd9
`endif
    } state_t;

    localparam logic [4:0] OP_HALT = 5'd27;

`ifdef CU_STEP_EN
    // Completed instructions pause here until the operator steps.
    localparam state_t ST_DONE = STEP_WAIT;
    logic unused_ir;
    assign unused_ir = ^IR[26:0];
`else
    localparam state_t ST_DONE = T0;
    logic unused_ir;
    assign unused_ir = ^{IR[26:0], step};
`endif

    state_t     state_q, state_d;
    logic [4:0] op_q, op_d;

    function automatic logic is_alu(input logic [4:0] op);
        return (op >= 5'd3) && (op <= 5'd11);
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == 5'd15) || (op == 5'd16);
    endfunction

    // Next-state and opcode latch decode.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            RST: state_d = T0;
            T0:  state_d = T1;
            T1:  if (mem_ready) state_d = T2;
            T2:  state_d = T3;
            T3: begin
                op_d = IR[31:27];
                if (is_alu(IR[31:27]) || is_muldiv(IR[31:27]))
                    state_d = T4;
                else if (IR[31:27] == OP_HALT)
                    state_d = HALT;
                else
                    state_d = ST_DONE;
            end
            T4:  state_d = T5;
            T5:  state_d = is_muldiv(op_q) ? T6 : ST_DONE;
            T6:  state_d = ST_DONE;
            HALT: state_d = HALT;
`ifdef CU_STEP_EN
            STEP_WAIT: if (step) state_d = T0;
`endif
            default: state_d = RST;
        endcase
    end

    // State and opcode registers with synchronous active-low clear.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q <= RST;
            op_q    <= 5'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Strobe decode from the current state; T3 looks at IR, T4-T6 at op_q.
    always_comb begin
        PCout    = 1'b0;
        PCin     = 1'b0;
        IncPC    = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        Read     = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        LOin     = 1'b0;
        HIin     = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        alu_op   = 5'd0;
        halted   = 1'b0;
        case (state_q)
            T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                if (is_alu(IR[31:27])) begin
                    Grb  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end else if (is_muldiv(IR[31:27])) begin
                    Gra  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end
            end
            T4: begin
                Rout   = 1'b1;
                Zin    = 1'b1;
                alu_op = op_q;
                if (is_muldiv(op_q))
                    Grb = 1'b1;
                else
                    Grc = 1'b1;
            end
            T5: begin
                Zlowout = 1'b1;
                if (is_muldiv(op_q)) begin
                    LOin = 1'b1;
                end else begin
                    Gra = 1'b1;
                    Rin = 1'b1;
                end
            end
            T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench for control_unit. Each cycle the expected
// output vector is queued as stimulus is applied and compared when sampled.
// Define CU_STEP_EN for both bench and design to exercise the step build.
module tb_control_unit;

    logic        clock;
    logic        clear;
    logic [31:0] IR;
    logic        mem_ready;
    logic        step;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, Zin;
    logic        Zlowout, Zhighout, LOin, HIin, Gra, Grb, Grc, Rin, Rout;
    logic [4:0]  alu_op;
    logic        halted;

    control_unit dut (
        .clock(clock), .clear(clear), .IR(IR), .mem_ready(mem_ready), .step(step),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .Read(Read), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .LOin(LOin), .HIin(HIin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .alu_op(alu_op), .halted(halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [24:0] obs;
    assign obs = {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, Zin,
                  Zlowout, Zhighout, LOin, HIin, Gra, Grb, Grc, Rin, Rout,
                  alu_op, halted};

    localparam logic [24:0] B_HALTED  = 25'd1 << 0;
    localparam logic [24:0] B_ROUT    = 25'd1 << 6;
    localparam logic [24:0] B_RIN     = 25'd1 << 7;
    localparam logic [24:0] B_GRC     = 25'd1 << 8;
    localparam logic [24:0] B_GRB     = 25'd1 << 9;
    localparam logic [24:0] B_GRA     = 25'd1 << 10;
    localparam logic [24:0] B_HIIN    = 25'd1 << 11;
    localparam logic [24:0] B_LOIN    = 25'd1 << 12;
    localparam logic [24:0] B_ZHIGH   = 25'd1 << 13;
    localparam logic [24:0] B_ZLOW    = 25'd1 << 14;
    localparam logic [24:0] B_ZIN     = 25'd1 << 15;
    localparam logic [24:0] B_YIN     = 25'd1 << 16;
    localparam logic [24:0] B_IRIN    = 25'd1 << 17;
    localparam logic [24:0] B_READ    = 25'd1 << 18;
    localparam logic [24:0] B_MDROUT  = 25'd1 << 19;
    localparam logic [24:0] B_MDRIN   = 25'd1 << 20;
    localparam logic [24:0] B_MARIN   = 25'd1 << 21;
    localparam logic [24:0] B_INCPC   = 25'd1 << 22;
    localparam logic [24:0] B_PCIN    = 25'd1 << 23;
    localparam logic [24:0] B_PCOUT   = 25'd1 << 24;

    localparam logic [24:0] E_ZERO = 25'd0;
    localparam logic [24:0] E_T0   = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
    localparam logic [24:0] E_T1   = B_ZLOW | B_PCIN | B_READ | B_MDRIN;
    localparam logic [24:0] E_T2   = B_MDROUT | B_IRIN;
    localparam logic [24:0] E_HALT = B_HALTED;

    logic [24:0] sb_q[$];
    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // One clock cycle: apply inputs, queue the expected outputs of the current
    // state, sample and compare, then advance past the next rising edge.
    task automatic cyc(input logic clr, input logic mr, input logic [31:0] ir,
                       input logic stp, input logic [24:0] exp, input string tag);
        logic [24:0] want;
        clear     = clr;
        mem_ready = mr;
        IR        = ir;
        step      = stp;
        sb_q.push_back(exp);
        #1;
        want = sb_q.pop_front();
        check(tag, {7'd0, obs}, {7'd0, want});
        @(posedge clock);
        #1;
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [24:0] op_bits(input logic [4:0] op);
        return {19'd0, op, 1'b0};
    endfunction

    task automatic fetch(input int waits);
        cyc(1'b1, rb(), $urandom, rb(), E_T0, "t0");
        for (int i = 0; i < waits; i++)
            cyc(1'b1, 1'b0, $urandom, rb(), E_T1, "t1_wait");
        cyc(1'b1, 1'b1, $urandom, rb(), E_T1, "t1_ready");
        cyc(1'b1, rb(), $urandom, rb(), E_T2, "t2");
    endtask

    task automatic done_path(input int hold);
`ifdef CU_STEP_EN
        for (int i = 0; i < hold; i++)
            cyc(1'b1, rb(), $urandom, 1'b0, E_ZERO, "step_hold");
        cyc(1'b1, rb(), $urandom, 1'b1, E_ZERO, "step_go");
`else
        if (hold < 0) $display("unused hold %0d", hold);
`endif
    endtask

    // Full instruction from T0; halt instructions stop after entering HALT.
    task automatic run_instr(input logic [31:0] ir, input int waits, input int hold);
        logic [4:0] op;
        op = ir[31:27];
        fetch(waits);
        if (op >= 5'd3 && op <= 5'd11) begin
            cyc(1'b1, rb(), ir, rb(), B_GRB | B_ROUT | B_YIN, "alu_t3");
            cyc(1'b1, rb(), $urandom, rb(), B_GRC | B_ROUT | B_ZIN | op_bits(op), "alu_t4");
            cyc(1'b1, rb(), $urandom, rb(), B_ZLOW | B_GRA | B_RIN, "alu_t5");
            done_path(hold);
        end else if (op == 5'd15 || op == 5'd16) begin
            cyc(1'b1, rb(), ir, rb(), B_GRA | B_ROUT | B_YIN, "md_t3");
            cyc(1'b1, rb(), $urandom, rb(), B_GRB | B_ROUT | B_ZIN | op_bits(op), "md_t4");
            cyc(1'b1, rb(), $urandom, rb(), B_ZLOW | B_LOIN, "md_t5");
            cyc(1'b1, rb(), $urandom, rb(), B_ZHIGH | B_HIIN, "md_t6");
            done_path(hold);
        end else if (op == 5'd27) begin
            cyc(1'b1, rb(), ir, rb(), E_ZERO, "halt_t3");
        end else begin
            cyc(1'b1, rb(), ir, rb(), E_ZERO, "nop_t3");
            done_path(hold);
        end
    endtask

    initial begin
        clear     = 1'b0;
        mem_ready = 1'b0;
        IR        = 32'd0;
        step      = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;

        // Held in reset, then released: fetch starts with T0.
        cyc(1'b0, 1'b1, $urandom, 1'b1, E_ZERO, "rst_hold");
        cyc(1'b1, 1'b1, $urandom, 1'b1, E_ZERO, "rst_release");

        // ADD, then step-wait hold of 5 cycles in the step build.
        run_instr(32'h1800_0000, 0, 5);
        // DIV with three memory wait cycles.
        run_instr(32'h8000_0000, 3, 0);
        run_instr({5'd4,  27'($urandom)}, 1, 0);
        run_instr({5'd11, 27'($urandom)}, 0, 2);
        run_instr({5'd15, 27'($urandom)}, 2, 0);
        run_instr({5'd26, 27'($urandom)}, 0, 0);
        run_instr({5'd0,  27'($urandom)}, 0, 1);
        run_instr({5'd12, 27'($urandom)}, 1, 0);
        run_instr({5'd2,  27'($urandom)}, 0, 0);
        run_instr({5'd31, 27'($urandom)}, 0, 0);
        run_instr({5'd7,  27'($urandom)}, 0, 0);

        // Clear for two edges starting mid-T4.
        fetch(0);
        cyc(1'b1, rb(), 32'h1800_0000, rb(), B_GRB | B_ROUT | B_YIN, "rst4_t3");
        cyc(1'b0, rb(), $urandom, rb(), B_GRC | B_ROUT | B_ZIN | op_bits(5'd3), "rst4_t4");
        cyc(1'b0, rb(), $urandom, rb(), E_ZERO, "rst4_rst");
        cyc(1'b1, rb(), $urandom, rb(), E_ZERO, "rst4_rel");

        // Clear during a T1 wait drops the read.
        cyc(1'b1, rb(), $urandom, rb(), E_T0, "rst1_t0");
        cyc(1'b0, 1'b0, $urandom, rb(), E_T1, "rst1_t1");
        cyc(1'b1, 1'b1, $urandom, rb(), E_ZERO, "rst1_rst");

        // Halt: 20 idle cycles, then one cycle of clear.
        run_instr(32'hD800_0000, 0, 0);
        for (int i = 0; i < 20; i++)
            cyc(1'b1, rb(), $urandom, rb(), E_HALT, "halt_hold");
        cyc(1'b0, rb(), $urandom, rb(), E_HALT, "halt_clear");
        cyc(1'b1, rb(), $urandom, rb(), E_ZERO, "halt_rst");

        run_instr({5'd16, 27'($urandom)}, 0, 0);
        cyc(1'b1, rb(), $urandom, rb(), E_T0, "final_t0");

        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
